// File: rtl/booth_mult_sequencer.sv
// Sequential radix-2 Booth multiplier for the EX stage: one partial-product step per
// cycle, stalls the pipeline while iterating, pulses done with a held 2*WIDTH product.
module booth_mult_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state_q;
    logic [WIDTH:0]       m_q;
    logic [WIDTH:0]       a_q;
    logic [WIDTH-1:0]     q_q;
    logic                 qm1_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   prod_q;

    logic                 accept;
    logic [WIDTH:0]       sum_d;
    logic [WIDTH:0]       a_d;
    logic [WIDTH-1:0]     q_d;
    logic                 qm1_d;

    // A carries one guard bit so that negating M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        accept = start & ~flush & (state_q != RUN);
        unique case ({q_q[0], qm1_q})
            2'b01:   sum_d = a_q + m_q;
            2'b10:   sum_d = a_q - m_q;
            default: sum_d = a_q;
        endcase
        a_d   = {sum_d[WIDTH], sum_d[WIDTH:1]};
        q_d   = {sum_d[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
    end

    assign stall   = rst_n & ((state_q == RUN) | accept);
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                RUN: begin
                    if (flush) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q   <= a_d;
                        q_q   <= q_d;
                        qm1_q <= qm1_d;
                        cnt_q <= cnt_q - 1'b1;
                        // Last step: capture the product from the freshly shifted values.
                        if (cnt_q == CW'(1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            prod_q  <= {a_d[WIDTH-1:0], q_d};
                        end
                    end
                end
                default: begin
                    if (accept) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        m_q     <= {multiplicand[WIDTH-1], multiplicand};
                        a_q     <= '0;
                        q_q     <= multiplier;
                        qm1_q   <= 1'b0;
                        cnt_q   <= CW'(WIDTH);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
